cordic_job_ctl: RTL and testbench
=================================

CORDIC_JOB_CTL -- requirements
Module: cordic_job_ctl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, job queue entries (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYCLES, default 200, maximum cycles to wait for cordic_done per job (<=255).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clka  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 job_valid  in  1  job offered upstream; job_ready  out  1  queue can accept.
REQ-007 job_mode  in  1 / job_op0  in  8 / job_op1  in  8  job mode and operands.
REQ-008 cordic_start  out  1 / cordic_mode  out  1 / cordic_in0  out  8 / cordic_in1  out  8  drive the CORDIC core.
REQ-009 cordic_done  in  1 / cordic_out0  in  8 / cordic_out1  in  8  core completion and results.
REQ-010 res_valid  out  1 / res_ready  in  1 / res_out0  out  8 / res_out1  out  8 / res_mode  out  1  result handshake downstream.
REQ-011 busy  out  1  job in flight; timeout_err  out  1  sticky error flag.

Function
REQ-012 Job accepted on clka edge with job_valid=1 and job_ready=1; job_ready = queue not full, registered-state derived, no combinational path from job_valid.
REQ-013 Queue FIFO order, FIFO_DEPTH entries of {mode, op0, op1}; pointers wrap modulo FIFO_DEPTH; simultaneous push and pop when non-empty and non-full both take effect, count unchanged.
REQ-014 FSM states IDLE, LAUNCH, WAIT.
REQ-015 IDLE -> LAUNCH when queue non-empty and res_valid=0 (or res_valid & res_ready in same cycle); head entry popped and latched into operand register that cycle.
REQ-016 LAUNCH: cordic_start=1 for exactly one cycle, then -> WAIT; cordic_start=0 in all other states.
REQ-017 cordic_mode, cordic_in0, cordic_in1 driven from operand register, stable from LAUNCH until WAIT exits.
REQ-018 WAIT: cordic_done ignored in LAUNCH; first WAIT cycle with cordic_done=1 captures cordic_out0/1 and operand mode into result register, sets res_valid, -> IDLE.
REQ-019 WAIT cycle counter starts at 0 on entry; if it reaches TIMEOUT_CYCLES with no done: timeout_err set, job discarded, res_valid unchanged, -> IDLE.
REQ-020 Result held stable while res_valid=1 and res_ready=0; res_valid clears on cycle after res_valid & res_ready.
REQ-021 busy = 1 in LAUNCH and WAIT, else 0.
REQ-022 timeout_err sticky; cleared only by reset.
REQ-023 Job latency: empty queue, idle, res_ready=1, core done N cycles after start -> res_valid asserted N+2 cycles after job acceptance edge.

Reset
REQ-024 Reset: FSM IDLE, queue empty, counters 0.
REQ-025 Reset values: job_ready=1, cordic_start=0, cordic_mode=0, cordic_in0/1=0, res_valid=0, res_out0/1=0, res_mode=0, busy=0, timeout_err=0.
REQ-026 Reset mid-job abandons in-flight job and queue contents; no cordic_start in the reset cycle or the cycle after.

Structure
REQ-027 Shared package holds FSM state encoding, job record width (17 bits), and default FIFO_DEPTH/TIMEOUT_CYCLES constants.
REQ-028 Queue implemented as sub-module cordic_job_fifo (push/pop, full/empty, registered storage); FSM, timeout counter and result register in cordic_job_ctl.

Verification
REQ-029 Single job: mode=0, op0=0x40, op1=0x00; model done after 10 cycles with out=0x2D/0x2D -> one start pulse, res_out0/1=0x2D, res_mode=0, res_valid at cycle 12 after acceptance.
REQ-030 Fill: 5 back-to-back jobs, core stalled, depth 4 -> job_ready=0 after 4th queued entry plus one in flight; results emerge in issue order.
REQ-031 Backpressure: res_ready=0 for 20 cycles with 2 jobs queued -> no second start until result taken; res_out stable throughout.
REQ-032 Timeout: done never asserted -> timeout_err=1 exactly TIMEOUT_CYCLES cycles into WAIT, no res_valid, next job launches normally, timeout_err stays 1.
REQ-033 Reset during WAIT -> all outputs reset values next cycle; prior queued jobs never launch.
REQ-034 Wrap: 10 jobs streamed with res_ready=1 -> pointers wrap twice, all 10 results in order, no loss or duplication.

Source files
------------

// File: rtl/cordic_job_ctl_pkg.sv
// Shared types and defaults for the CORDIC job controller: FSM encoding,
// the queued job record and the default queue depth / timeout.
package cordic_job_ctl_pkg;

  localparam int JOB_W                  = 17;
  localparam int DEFAULT_FIFO_DEPTH     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  // Field order matches the packed vector stored in the job queue.
  typedef struct packed {
    logic       mode;
    logic [7:0] op0;
    logic [7:0] op1;
  } job_t;

endpackage

// File: rtl/cordic_job_ctl_if.sv
// Bundle of the job, core and result handshakes around cordic_job_ctl.
// The slave modport is the controller's view; master is the environment's.
interface cordic_job_ctl_if;

  logic       job_valid;
  logic       job_ready;
  logic       job_mode;
  logic [7:0] job_op0;
  logic [7:0] job_op1;

  logic       cordic_start;
  logic       cordic_mode;
  logic [7:0] cordic_in0;
  logic [7:0] cordic_in1;
  logic       cordic_done;
  logic [7:0] cordic_out0;
  logic [7:0] cordic_out1;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_out0;
  logic [7:0] res_out1;
  logic       res_mode;

  logic       busy;
  logic       timeout_err;

  modport slave (
    input  job_valid, job_mode, job_op0, job_op1,
    output job_ready,
    output cordic_start, cordic_mode, cordic_in0, cordic_in1,
    input  cordic_done, cordic_out0, cordic_out1,
    output res_valid, res_out0, res_out1, res_mode,
    input  res_ready,
    output busy, timeout_err
  );

  modport master (
    output job_valid, job_mode, job_op0, job_op1,
    input  job_ready,
    input  cordic_start, cordic_mode, cordic_in0, cordic_in1,
    output cordic_done, cordic_out0, cordic_out1,
    input  res_valid, res_out0, res_out1, res_mode,
    output res_ready,
    input  busy, timeout_err
  );

endinterface

// File: rtl/cordic_job_fifo.sv
// Job queue for cordic_job_ctl: power-of-two ring buffer with
// registered pointers and an occupancy count driving full/empty.
module cordic_job_fifo
  import cordic_job_ctl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clka,
  input  logic             reset,
  input  logic             i_push,
  input  logic [JOB_W-1:0] i_data,
  input  logic             i_pop,
  output logic [JOB_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [JOB_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone decide which entries are valid, so it can map onto plain RAM.
  always_ff @(posedge clka) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clka) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_job_ctl.sv
// Feeds queued jobs to a CORDIC core one at a time, enforces a per-job
// completion timeout and holds each result until downstream takes it.
module cordic_job_ctl
  import cordic_job_ctl_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clka,
  input  logic             reset,
  cordic_job_ctl_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  job_t             r_op;
  logic [7:0]       r_wait_cnt;
  logic             r_res_valid;
  logic             r_res_mode;
  logic [7:0]       r_res_out0;
  logic [7:0]       r_res_out1;
  logic             r_timeout_err;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_timeout;
  logic             w_res_free;
  logic [JOB_W-1:0] w_head;

  assign w_push     = bus.job_valid && !w_fifo_full;
  // The result slot is free if empty or being drained on this very edge.
  assign w_res_free = !r_res_valid || bus.res_ready;

  cordic_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clka    (clka),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({bus.job_mode, bus.job_op0, bus.job_op1}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clka) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty && w_res_free) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.cordic_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      r_op          <= '0;
      r_wait_cnt    <= '0;
      r_res_valid   <= 1'b0;
      r_res_mode    <= 1'b0;
      r_res_out0    <= '0;
      r_res_out1    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_pop) r_op <= job_t'(w_head);

      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                   r_wait_cnt <= '0;

      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_mode  <= r_op.mode;
        r_res_out0  <= bus.cordic_out0;
        r_res_out1  <= bus.cordic_out1;
      end else if (r_res_valid && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end

      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  // Start is masked during reset so a LAUNCH cut short never reaches the core.
  assign bus.cordic_start = (r_state == S_LAUNCH) && !reset;
  assign bus.cordic_mode  = r_op.mode;
  assign bus.cordic_in0   = r_op.op0;
  assign bus.cordic_in1   = r_op.op1;
  assign bus.job_ready    = !w_fifo_full;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_mode     = r_res_mode;
  assign bus.res_out0     = r_res_out0;
  assign bus.res_out1     = r_res_out1;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_cordic_job_ctl.sv
// Scoreboard bench for cordic_job_ctl: directed jobs push expected results,
// a behavioural core answers start pulses, and a monitor checks each result.
module tb_cordic_job_ctl;
  import cordic_job_ctl_pkg::*;

  localparam int T = DEFAULT_TIMEOUT_CYCLES;

  typedef struct packed {
    logic       mode;
    logic [7:0] o0;
    logic [7:0] o1;
  } exp_t;

  logic clka  = 1'b1;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_starts = 0;
  int   n_results = 0;
  int   last_start_cyc = 0;
  exp_t sb[$];

  bit         core_stall = 1'b0;
  bit         core_mute  = 1'b0;
  int         core_delay = 10;
  bit         m_pend = 1'b0;
  int         m_cnt = 0;
  logic       m_mode;
  logic [7:0] m_op0, m_op1;
  bit         prev_start = 1'b0;

  bit         hold_v = 1'b0;
  logic       hold_mode;
  logic [7:0] hold_o0, hold_o1;

  cordic_job_ctl_if bus ();

  cordic_job_ctl #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clka  (clka),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in for the CORDIC core; the 0x40/0x00 pair gives the 45-degree answer.
  function automatic logic [15:0] core_fn(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h40 && b == 8'h00) return 16'h2D2D;
    return {8'(a + b), 8'(a - b)};
  endfunction

  always @(negedge clka) begin
    bus.cordic_done = 1'b0;
    bus.cordic_out0 = 8'hEE;
    bus.cordic_out1 = 8'hEE;
    if (reset) begin
      m_pend     = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (bus.cordic_start) begin
        n_starts++;
        last_start_cyc = cyc;
        check("start_single_cycle", {31'd0, prev_start}, 32'd0);
        if (!core_mute) begin
          m_pend = 1'b1;
          m_cnt  = core_delay;
          m_mode = bus.cordic_mode;
          m_op0  = bus.cordic_in0;
          m_op1  = bus.cordic_in1;
        end
      end else if (m_pend) begin
        if (m_cnt > 0) m_cnt--;
        if (m_cnt == 0 && !core_stall) begin
          check("cordic_in_stable", {15'd0, bus.cordic_mode, bus.cordic_in0, bus.cordic_in1},
                {15'd0, m_mode, m_op0, m_op1});
          {bus.cordic_out0, bus.cordic_out1} = core_fn(m_op0, m_op1);
          bus.cordic_done = 1'b1;
          m_pend = 1'b0;
        end
      end
      prev_start = bus.cordic_start;
    end
  end

  always @(negedge clka) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        check("res_hold", {15'd0, bus.res_valid, bus.res_mode, bus.res_out0, bus.res_out1},
              {15'd0, 1'b1, hold_mode, hold_o0, hold_o1});
      if (bus.res_valid && bus.res_ready) begin
        exp_t e;
        n_results++;
        check("result_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("res_data", {15'd0, bus.res_mode, bus.res_out0, bus.res_out1}, {15'd0, e});
        end
        hold_v = 1'b0;
      end else begin
        hold_v    = bus.res_valid;
        hold_mode = bus.res_mode;
        hold_o0   = bus.res_out0;
        hold_o1   = bus.res_out1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic push_job(input logic mode, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input bit expect_res);
    int guard = 0;
    bus.job_valid = 1'b1;
    bus.job_mode  = mode;
    bus.job_op0   = a;
    bus.job_op1   = b;
    while (!bus.job_ready && guard < 500) begin
      tick();
      guard++;
    end
    if (guard >= 500) check("job_accept_bound", guard, 32'd0);
    acc_cyc = cyc + 1;
    if (expect_res) sb.push_back({mode, exp});
    tick();
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int g = 0;
    while ((sb.size() != 0 || bus.busy || bus.res_valid) && g < bound) begin
      tick();
      g++;
    end
    check(name, {29'd0, sb.size() == 0, !bus.busy, !bus.res_valid}, 32'd7);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"},    {31'd0, bus.job_ready},    32'd1);
    check({tag, "_cordic_start"}, {31'd0, bus.cordic_start}, 32'd0);
    check({tag, "_cordic_ops"},   {15'd0, bus.cordic_mode, bus.cordic_in0, bus.cordic_in1}, 32'd0);
    check({tag, "_res_valid"},    {31'd0, bus.res_valid},    32'd0);
    check({tag, "_res_data"},     {15'd0, bus.res_mode, bus.res_out0, bus.res_out1}, 32'd0);
    check({tag, "_busy"},         {31'd0, bus.busy},         32'd0);
    check({tag, "_timeout_err"},  {31'd0, bus.timeout_err},  32'd0);
  endtask

  logic [7:0]  wrap_op0 [10] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                                 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
  logic [15:0] wrap_exp [10] = '{16'h01FF, 16'h1210, 16'h2321, 16'h3432, 16'h4543,
                                 16'h5654, 16'h6765, 16'h7876, 16'h8987, 16'h9A98};

  initial begin
    int s0, r0, g, l;
    bus.job_valid = 1'b0;
    bus.job_mode  = 1'b0;
    bus.job_op0   = 8'h00;
    bus.job_op1   = 8'h00;
    bus.res_ready = 1'b1;

    reset = 1'b1;
    tick(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Single job: start one cycle after acceptance, result 12 cycles after it.
    core_delay = 10;
    push_job(1'b0, 8'h40, 8'h00, 16'h2D2D, 1'b1);
    tick();
    check("launch_state", {22'd0, bus.busy, bus.cordic_start, bus.cordic_in0}, {22'd0, 1'b1, 1'b1, 8'h40});
    g = 0;
    while (!bus.res_valid && g < 40) begin
      tick();
      g++;
    end
    check("single_latency", cyc - acc_cyc, 32'd12);
    wait_drain("single_drain", 50);
    check("single_starts", n_starts, 32'd1);

    // Fill: stalled core, four queued plus one in flight closes job_ready.
    core_stall = 1'b1;
    core_delay = 3;
    s0 = n_starts;
    push_job(1'b1, 8'h10, 8'h20, 16'h30F0, 1'b1);
    push_job(1'b0, 8'h33, 8'h11, 16'h4422, 1'b1);
    push_job(1'b1, 8'h80, 8'h80, 16'h0000, 1'b1);
    push_job(1'b0, 8'hFF, 8'h01, 16'h00FE, 1'b1);
    push_job(1'b1, 8'h7F, 8'h01, 16'h807E, 1'b1);
    check("fill_job_ready", {31'd0, bus.job_ready}, 32'd0);
    check("fill_busy_starts", {bus.busy, 31'(n_starts - s0)}, {1'b1, 31'd1});
    tick(5);
    check("fill_still_full", {31'd0, bus.job_ready}, 32'd0);
    core_stall = 1'b0;
    wait_drain("fill_drain", 400);
    check("fill_ready_back", {31'd0, bus.job_ready}, 32'd1);

    // Backpressure: held result blocks the second launch.
    bus.res_ready = 1'b0;
    core_delay = 2;
    s0 = n_starts;
    r0 = n_results;
    push_job(1'b0, 8'h01, 8'h02, 16'h03FF, 1'b1);
    push_job(1'b1, 8'hA0, 8'h05, 16'hA59B, 1'b1);
    g = 0;
    while (!bus.res_valid && g < 40) begin
      tick();
      g++;
    end
    tick(20);
    check("bp_starts", n_starts - s0, 32'd1);
    check("bp_held", {31'd0, bus.res_valid}, 32'd1);
    check("bp_no_results", n_results - r0, 32'd0);
    bus.res_ready = 1'b1;
    wait_drain("bp_drain", 100);
    check("bp_starts_total", n_starts - s0, 32'd2);

    // Timeout: a silent core trips the sticky flag after T WAIT cycles.
    core_mute = 1'b1;
    s0 = n_starts;
    push_job(1'b0, 8'h12, 8'h34, 16'h0000, 1'b0);
    g = 0;
    while (n_starts == s0 && g < 20) begin
      tick();
      g++;
    end
    l = last_start_cyc;
    g = 0;
    while (cyc < l + T && g < T + 20) begin
      tick();
      g++;
    end
    check("to_before", {bus.timeout_err, 31'(cyc - l)}, {1'b0, 31'(T)});
    tick();
    check("to_at", {29'd0, bus.timeout_err, bus.res_valid, bus.busy}, 32'd4);
    core_mute = 1'b0;
    push_job(1'b1, 8'h05, 8'h03, 16'h0802, 1'b1);
    wait_drain("to_next_drain", 100);
    check("to_sticky", {31'd0, bus.timeout_err}, 32'd1);

    // Reset mid-WAIT discards the in-flight job and the queue.
    core_stall = 1'b1;
    core_delay = 2;
    push_job(1'b0, 8'h01, 8'h01, 16'h0200, 1'b1);
    push_job(1'b1, 8'h02, 8'h01, 16'h0301, 1'b1);
    push_job(1'b0, 8'h03, 8'h01, 16'h0402, 1'b1);
    tick(4);
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    sb.delete();
    core_stall = 1'b0;
    s0 = n_starts;
    r0 = n_results;
    tick(30);
    check("midrst_no_launch", {n_starts - s0}, 32'd0);
    check("midrst_no_result", {n_results - r0}, 32'd0);

    // Wrap: ten streamed jobs take the pointers around twice.
    core_delay = 1;
    s0 = n_starts;
    r0 = n_results;
    for (int i = 0; i < 10; i++) begin
      push_job(1'(i % 2), wrap_op0[i], 8'h01, wrap_exp[i], 1'b1);
    end
    wait_drain("wrap_drain", 1000);
    check("wrap_results", n_results - r0, 32'd10);
    check("wrap_starts", n_starts - s0, 32'd10);

    check("sb_empty_end", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
